// File: rtl/ddr_rd_bw_sched.sv
// Sequencer for the DDR bandwidth test: issues a programmed series of single-burst reads
// through the burst reader's START/IDLE handshake and counts AXIS beats and elapsed cycles.
module ddr_rd_bw_sched #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  CTRL_START,
    input  logic [31:0]           CTRL_BASE,
    input  logic [31:0]           CTRL_LEN,
    input  logic [31:0]           CTRL_NBURST,
    input  logic [31:0]           CTRL_STRIDE,
    output logic                  STAT_BUSY,
    output logic                  STAT_DONE,
    output logic [1:0]            STAT_ERR,
    output logic [CNT_WIDTH-1:0]  STAT_CYCLES,
    output logic [CNT_WIDTH-1:0]  STAT_BEATS,
    output logic                  rd_start,
    output logic [31:0]           rd_addr,
    output logic [31:0]           rd_len,
    input  logic                  rd_idle,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready
);
    localparam int BPB = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_ACK, WAIT_DONE, NEXT} state_t;

    state_t                 state_reg, state_next;
    logic                   start_d_reg;
    logic [31:0]            len_reg, len_next;
    logic [31:0]            remaining_reg, remaining_next;
    logic [31:0]            stride_reg, stride_next;
    logic [31:0]            addr_reg, addr_next;
    logic                   first_reg, first_next;
    logic                   counting_reg, counting_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic [1:0]             err_reg, err_next;
    logic [CNT_WIDTH-1:0]   cycles_reg, cycles_next;
    logic [CNT_WIDTH-1:0]   beats_reg, beats_next;
    logic                   rd_start_reg, rd_start_next;
    logic [31:0]            rd_addr_reg, rd_addr_next;
    logic [31:0]            rd_len_reg, rd_len_next;

    logic                   start_edge;
    logic                   clear;
    logic                   beat;
    logic [47:0]            end_addr;
    logic                   tdata_unused;

    assign tdata_unused  = ^s_axis_tdata;
    assign s_axis_tready = rstn;
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign start_edge    = CTRL_START & ~start_d_reg;
    // Only meaningful once LEN has passed the range check in the same cycle.
    assign end_addr      = 48'(addr_reg[11:0]) + 48'(len_reg) * 48'(BPB);

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        remaining_next = remaining_reg;
        stride_next    = stride_reg;
        addr_next      = addr_reg;
        first_next     = first_reg;
        counting_next  = counting_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        err_next       = err_reg;
        rd_start_next  = rd_start_reg;
        rd_addr_next   = rd_addr_reg;
        rd_len_next    = rd_len_reg;
        clear          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    len_next       = CTRL_LEN;
                    remaining_next = CTRL_NBURST;
                    stride_next    = CTRL_STRIDE;
                    addr_next      = CTRL_BASE;
                    first_next     = 1'b1;
                    busy_next      = 1'b1;
                    done_next      = 1'b0;
                    err_next       = 2'd0;
                    clear          = 1'b1;
                    state_next     = CHECK;
                end
            end
            CHECK: begin
                if (len_reg == 32'd0 || len_reg > 32'd256 || remaining_reg == 32'd0) begin
                    err_next      = 2'd1;
                    busy_next     = 1'b0;
                    counting_next = 1'b0;
                    state_next    = IDLE;
                end else if (end_addr > 48'd4096) begin
                    err_next      = 2'd2;
                    busy_next     = 1'b0;
                    counting_next = 1'b0;
                    state_next    = IDLE;
                end else begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // The reader must be idle before the very first start of a run.
                if (!first_reg || rd_idle) begin
                    rd_addr_next  = addr_reg;
                    rd_len_next   = len_reg;
                    rd_start_next = 1'b1;
                    first_next    = 1'b0;
                    if (first_reg) begin
                        counting_next = 1'b1;
                    end
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!rd_idle) begin
                    rd_start_next = 1'b0;
                    state_next    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rd_idle) begin
                    if (remaining_reg == 32'd1) begin
                        counting_next = 1'b0;
                    end
                    state_next = NEXT;
                end
            end
            NEXT: begin
                remaining_next = remaining_reg - 32'd1;
                if (remaining_reg == 32'd1) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    addr_next  = addr_reg + stride_reg;
                    state_next = CHECK;
                end
            end
            default: state_next = IDLE;
        endcase

        cycles_next = cycles_reg;
        if (clear) begin
            cycles_next = '0;
        end else if (counting_reg && cycles_reg != '1) begin
            cycles_next = cycles_reg + 1'b1;
        end

        // A run-start clear takes priority over a beat in the same cycle.
        beats_next = beats_reg;
        if (clear) begin
            beats_next = '0;
        end else if (beat && beats_reg != '1) begin
            beats_next = beats_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            start_d_reg   <= 1'b0;
            len_reg       <= '0;
            remaining_reg <= '0;
            stride_reg    <= '0;
            addr_reg      <= '0;
            first_reg     <= 1'b0;
            counting_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= '0;
            cycles_reg    <= '0;
            beats_reg     <= '0;
            rd_start_reg  <= 1'b0;
            rd_addr_reg   <= '0;
            rd_len_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            start_d_reg   <= CTRL_START;
            len_reg       <= len_next;
            remaining_reg <= remaining_next;
            stride_reg    <= stride_next;
            addr_reg      <= addr_next;
            first_reg     <= first_next;
            counting_reg  <= counting_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            cycles_reg    <= cycles_next;
            beats_reg     <= beats_next;
            rd_start_reg  <= rd_start_next;
            rd_addr_reg   <= rd_addr_next;
            rd_len_reg    <= rd_len_next;
        end
    end

    assign STAT_BUSY   = busy_reg;
    assign STAT_DONE   = done_reg;
    assign STAT_ERR    = err_reg;
    assign STAT_CYCLES = cycles_reg;
    assign STAT_BEATS  = beats_reg;
    assign rd_start    = rd_start_reg;
    assign rd_addr     = rd_addr_reg;
    assign rd_len      = rd_len_reg;
endmodule

// File: tb/tb_ddr_rd_bw_sched.sv
// Bench for ddr_rd_bw_sched: a behavioural burst-reader model answers the handshake and
// a run-level reference predicts addresses, error code, beat and cycle counts.
module tb_ddr_rd_bw_sched;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        CTRL_START = 1'b0;
    logic [31:0] CTRL_BASE = '0, CTRL_LEN = '0, CTRL_NBURST = '0, CTRL_STRIDE = '0;
    logic        STAT_BUSY, STAT_DONE;
    logic [1:0]  STAT_ERR;
    logic [31:0] STAT_CYCLES, STAT_BEATS;
    logic        rd_start;
    logic [31:0] rd_addr, rd_len;
    logic        rd_idle = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tready;

    ddr_rd_bw_sched #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .CTRL_START(CTRL_START), .CTRL_BASE(CTRL_BASE),
        .CTRL_LEN(CTRL_LEN), .CTRL_NBURST(CTRL_NBURST), .CTRL_STRIDE(CTRL_STRIDE),
        .STAT_BUSY(STAT_BUSY), .STAT_DONE(STAT_DONE), .STAT_ERR(STAT_ERR),
        .STAT_CYCLES(STAT_CYCLES), .STAT_BEATS(STAT_BEATS), .rd_start(rd_start),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_idle(rd_idle),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     vectors = 0;
    int     miscompares = 0;
    longint beats_exp = 0;
    int     t0 = 0, t1 = 0, te = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reader model for one burst: acknowledge, stream len beats, then return to idle.
    task automatic do_burst(input logic [31:0] a, input logic [31:0] l, input int ack_dly,
                            input int done_dly, input bit first, input bit last);
        bit ok;
        int n;
        bit v;
        wait_start(ok);
        chk("start_seen", 64'(ok), 64'd1);
        if (!ok) return;
        if (first) t0 = cyc;
        chk("rd_addr", 64'(rd_addr), 64'(a));
        chk("rd_len", 64'(rd_len), 64'(l));
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            chk("start_hold", 64'(rd_start), 64'd1);
        end
        rd_idle = 1'b0;
        @(negedge clk);
        chk("start_drop", 64'(rd_start), 64'd0);
        n = 0;
        while (n < int'(l)) begin
            v = ($urandom_range(0, 3) != 0);
            s_axis_tvalid = v;
            s_axis_tdata  = {$urandom, $urandom};
            if (v) begin
                n++;
                beats_exp++;
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < done_dly; i++) begin
            CTRL_START = (i == 0);
            chk("no_early_next", 64'({rd_start, STAT_DONE, STAT_BUSY}), 64'b001);
            @(negedge clk);
        end
        CTRL_START = 1'b0;
        rd_idle = 1'b1;
        if (last) t1 = cyc + 1;
    endtask

    task automatic idle_beats();
        int k;
        k = $urandom_range(0, 4);
        for (int i = 0; i < k; i++) begin
            s_axis_tvalid = 1'b1;
            beats_exp++;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("idle_beats", 64'(STAT_BEATS), 64'(beats_exp));
    endtask

    task automatic run(input logic [31:0] base, input logic [31:0] len, input logic [31:0] nb,
                       input logic [31:0] stride, input int ack_dly, input int done_dly,
                       input bit beat_on_start, input int idle_low);
        logic [31:0] addrs[$];
        logic [31:0] a;
        int          err;
        bit          saw_start;
        err = 0;
        if (len == 0 || len > 256 || nb == 0) begin
            err = 1;
        end else begin
            for (int i = 0; i < int'(nb); i++) begin
                a = base + stride * 32'(i);
                if ((a % 4096) + len * 8 > 4096) begin
                    err = 2;
                    break;
                end
                addrs.push_back(a);
            end
        end

        @(negedge clk);
        if (idle_low > 0) rd_idle = 1'b0;
        CTRL_BASE = base; CTRL_LEN = len; CTRL_NBURST = nb; CTRL_STRIDE = stride;
        CTRL_START = 1'b1;
        s_axis_tvalid = beat_on_start;
        @(negedge clk);
        te = cyc;
        CTRL_START = 1'b0;
        s_axis_tvalid = 1'b0;
        beats_exp = 0;
        chk("busy_set", 64'(STAT_BUSY), 64'd1);
        chk("beats_clr", 64'(STAT_BEATS), 64'd0);
        chk("done_clr", 64'({STAT_DONE, STAT_ERR}), 64'd0);
        for (int i = 0; i < idle_low; i++) begin
            @(negedge clk);
            chk("first_wait", 64'(rd_start), 64'd0);
        end
        rd_idle = 1'b1;

        foreach (addrs[i]) begin
            do_burst(addrs[i], len, ack_dly, done_dly, i == 0,
                     (i == addrs.size() - 1) && (err == 0));
            if (i == 0 && idle_low == 0) chk("latency", 64'(t0 - te), 64'd2);
        end

        saw_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_start) saw_start = 1'b1;
        end
        chk("no_extra_start", 64'(saw_start), 64'd0);
        chk("busy_end", 64'(STAT_BUSY), 64'd0);
        chk("done", 64'(STAT_DONE), 64'(err == 0));
        chk("err", 64'(STAT_ERR), 64'(err));
        chk("beats", 64'(STAT_BEATS), 64'(beats_exp));
        if (err == 0) chk("cycles", 64'(STAT_CYCLES), 64'(t1 - t0));
        else if (addrs.size() == 0) chk("cycles_err", 64'(STAT_CYCLES), 64'd0);
        $display("run base=%08h len=%0d nburst=%0d stride=%0h err=%0d beats=%0d cycles=%0d",
                 base, len, nb, stride, STAT_ERR, STAT_BEATS, STAT_CYCLES);
        idle_beats();
    endtask

    initial begin
        bit ok;
        logic [31:0] rl, rn;
        int n;

        #1;
        chk("rst_outputs", 64'({STAT_BUSY, STAT_DONE, STAT_ERR, rd_start, s_axis_tready}), 64'd0);
        chk("rst_counts", 64'({STAT_CYCLES, STAT_BEATS}), 64'd0);
        chk("rst_rd", 64'({rd_addr, rd_len}), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("tready", 64'(s_axis_tready), 64'd1);

        run(32'h1000, 16, 1, 0, 0, 2, 0, 0);
        run(32'h0, 8, 4, 32'h100, 1, 3, 0, 0);
        run(32'h0F80, 32, 1, 0, 0, 2, 0, 0);
        run(32'h0F80, 16, 1, 0, 0, 2, 0, 0);
        run(32'h0E80, 32, 4, 32'h100, 0, 2, 0, 0);
        run(32'h0, 0, 1, 0, 0, 2, 0, 0);
        run(32'h0, 257, 1, 0, 0, 2, 0, 0);
        run(32'h0, 4, 0, 0, 0, 2, 0, 0);
        run(32'h0, 256, 1, 0, 0, 2, 0, 0);
        run(32'h40, 4, 2, 32'h10, 10, 50, 0, 0);
        run(32'h200, 4, 1, 0, 0, 2, 1, 0);
        run(32'h300, 4, 2, 8, 0, 2, 0, 5);
        run(32'hFFFF_FF00, 4, 2, 32'h200, 0, 2, 0, 0);

        // Asynchronous reset in the middle of burst 2 of 4.
        @(negedge clk);
        CTRL_BASE = 32'h2000; CTRL_LEN = 8; CTRL_NBURST = 4; CTRL_STRIDE = 32'h40;
        CTRL_START = 1'b1;
        @(negedge clk);
        CTRL_START = 1'b0;
        beats_exp = 0;
        do_burst(32'h2000, 8, 0, 2, 1, 0);
        wait_start(ok);
        chk("rst_run_start2", 64'(ok), 64'd1);
        chk("rst_run_addr2", 64'(rd_addr), 64'h2040);
        rd_idle = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        chk("rst_run_busy", 64'(STAT_BUSY), 64'd1);
        #2 rstn = 1'b0;
        rd_idle = 1'b1;
        #1;
        chk("midrst_outputs", 64'({STAT_BUSY, STAT_DONE, STAT_ERR, rd_start, s_axis_tready}), 64'd0);
        chk("midrst_counts", 64'({STAT_CYCLES, STAT_BEATS}), 64'd0);
        chk("midrst_rd", 64'({rd_addr, rd_len}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        beats_exp = 0;
        run(32'h3000, 8, 4, 32'h40, 1, 2, 0, 0);

        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 15);
            rl = (n == 0) ? 32'd0 : (n == 1) ? 32'd257 : 32'($urandom_range(1, 24));
            rn = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 3));
            run($urandom, rl, rn, 32'($urandom_range(0, 64)) * 8, $urandom_range(0, 3),
                $urandom_range(1, 5), 1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ddr_rd_bw_sched.md
Name: ddr_rd_bw_sched

Overview:
Sequencer for the AXI burst reader in the DDR bandwidth test. It issues a programmed series of single-burst reads through the reader's START/ADDR/LENGTH/RIDLE register handshake, stepping the address by a stride each time. It sinks the reader's AXIS output stream, counting beats and elapsed cycles so software can compute read bandwidth.

Parameters:
DATA_WIDTH, 64, reader data width in bits; bytes per beat BPB = DATA_WIDTH/8
CNT_WIDTH, 32, width of the cycle and beat counters

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
CTRL_START  in  1  level; rising edge starts a test run
CTRL_BASE  in  32  address of the first burst, in bytes
CTRL_LEN  in  32  beats per burst, legal range 1..256
CTRL_NBURST  in  32  number of bursts, legal range >=1
CTRL_STRIDE  in  32  byte increment between burst addresses
STAT_BUSY  out  1  run in progress
STAT_DONE  out  1  sticky; set at the end of a successful run
STAT_ERR  out  2  sticky code: 0 none, 1 bad LEN/NBURST, 2 4 kB crossing
STAT_CYCLES  out  CNT_WIDTH  cycles from first rd_start to last burst done
STAT_BEATS  out  CNT_WIDTH  AXIS beats received
rd_start  out  1  drives reader START_REG
rd_addr  out  32  drives reader ADDR_REG
rd_len  out  32  drives reader LENGTH_REG
rd_idle  in  1  reader RIDLE_REG
s_axis_tvalid  in  1  reader m_axis_tvalid
s_axis_tdata  in  DATA_WIDTH  data; discarded
s_axis_tready  out  1  high whenever rstn is high

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-run drops rd_start immediately. The reader is expected to be reset on the same rstn.
- CTRL_START is edge-detected with a 1-cycle registered copy. An edge seen while not in IDLE is ignored.
- States:
  - IDLE: on an edge, latch CTRL_* into internal registers; clear DONE, ERR, CYCLES and BEATS; go to CHECK. STAT_BUSY becomes 1 on leaving IDLE.
  - CHECK (1 cycle): if LEN==0, LEN>256 or NBURST==0, set ERR=1 and go to IDLE. Otherwise compute end = cur_addr[11:0] + LEN*BPB with 13-bit or wider arithmetic. If end > 4096, set ERR=2 and go to IDLE. Otherwise go to ISSUE.
  - ISSUE: rd_addr=cur_addr and rd_len=LEN, both registered and stable until the burst completes. Assert rd_start=1 and go to WAIT_ACK.
  - WAIT_ACK: hold rd_start=1 until rd_idle==0, meaning the reader has left its start state. Then deassert rd_start and go to WAIT_DONE.
  - WAIT_DONE: wait for rd_idle==1, meaning the reader has returned to start. Then go to NEXT.
  - NEXT: decrement remaining. If remaining reaches 0, set DONE=1 and go to IDLE. Otherwise cur_addr += STRIDE (mod 2^32) and go to CHECK.
- On the first ISSUE of a run, rd_idle must be 1. If it is 0, wait in ISSUE without asserting rd_start until it is 1.
- STAT_CYCLES counts +1 every cycle from the cycle rd_start first rises through the cycle WAIT_DONE exits for the last burst. It saturates at all-ones.
- STAT_BEATS counts +1 on every cycle with s_axis_tvalid & s_axis_tready, in any state including IDLE. It saturates at all-ones and is cleared only at run start.
- Simultaneous beat and run-start clear in the same cycle: the clear wins and BEATS = 0.
- An error aborts the remaining bursts. Bursts already completed stay counted in BEATS.
- rd_start is driven directly from a register, never from combinational logic.
- Latency: rd_start rises 3 cycles after the CTRL_START edge: latch, CHECK, ISSUE.

Test Plan:
- Single burst: BASE=0x1000, LEN=16, NBURST=1 -> one rd_start pulse with rd_addr=0x1000, rd_len=16; BEATS=16; DONE=1; ERR=0; BUSY returns to 0.
- Multi-burst: BASE=0, LEN=8, STRIDE=0x100, NBURST=4 -> rd_addr sequence 0x0, 0x100, 0x200, 0x300; BEATS=32; CYCLES > 0; DONE=1.
- 4 kB crossing: BASE=0x0F80, LEN=32 (BPB=8, end 0x1080) -> ERR=2; no rd_start ever asserted; BEATS=0.
- Illegal parameters: LEN=0 -> ERR=1. LEN=257 -> ERR=1. NBURST=0 -> ERR=1. In every case rd_start stays 0.
- Handshake stall: hold rd_idle=1 for 10 cycles after rd_start rises -> rd_start stays 1 throughout. Slow rd_idle return (50 cycles) -> NEXT is not entered early.
- Reset mid-run during WAIT_DONE of burst 2 of 4 -> all outputs 0 asynchronously. A new CTRL_START edge after reset runs a full test correctly.
